// File: rtl/line_recip_pkg.sv
// line_recip shared types and constants.
// LINE_RECIP_ROUND_EN selects the rounding build (one extra guard iteration).
package line_recip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

`ifdef LINE_RECIP_ROUND_EN
  localparam int LINE_RECIP_RND = 1;
`else
  localparam int LINE_RECIP_RND = 0;
`endif

  // Latency for the default 11-bit result width.
  localparam int LINE_RECIP_LAT = 11 + LINE_RECIP_RND + 1;

  function automatic logic [15:0] sat_val(input int w);
    return 16'((1 << w) - 1);
  endfunction

endpackage

// File: rtl/line_recip_step.sv
// One restoring-division step: shift remainder, subtract divisor if it fits.
// Combinational only.
module line_recip_step #(
  parameter int DEN_W = 9
) (
  input  logic [DEN_W:0]   r,
  input  logic [DEN_W-1:0] d,
  output logic [DEN_W:0]   r_next,
  output logic             qbit
);

  logic [DEN_W+1:0] t;
  logic [DEN_W+1:0] diff;

  always_comb begin
    t      = {r, 1'b0};
    diff   = t - {2'b00, d};
    qbit   = (t >= {2'b00, d});
    r_next = qbit ? diff[DEN_W:0] : t[DEN_W:0];
  end

endmodule

// File: rtl/line_recip.sv
// Iterative fixed-point reciprocal: recip ~= 2^NUM_W / denom, saturated.
// Define LINE_RECIP_ROUND_EN for round-half-up instead of floor.
module line_recip
  import line_recip_pkg::*;
#(
  parameter int NUM_W = 16,
  parameter int DEN_W = 9,
  parameter int OUT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEN_W-1:0] denom,
  output logic [OUT_W-1:0] recip,
  output logic             busy,
  output logic             valid,
  output logic             sat
);

  localparam int N  = OUT_W + LINE_RECIP_RND;
  localparam int R0 = 1 << (NUM_W - OUT_W);
  localparam logic [15:0] SAT = sat_val(OUT_W);

  state_t           state, nxt;
  logic [DEN_W-1:0] d;
  logic [DEN_W:0]   r, r_nx;
  logic [N-1:0]     q, q_nx;
  logic [3:0]       cnt;
  logic             s, qb, last;
  logic [OUT_W-1:0] fin;
  logic             fin_sat;

  line_recip_step #(.DEN_W(DEN_W)) u_step (
    .r      (r),
    .d      (d),
    .r_next (r_nx),
    .qbit   (qb)
  );

  assign q_nx  = (q << 1) | N'(qb);
  assign last  = (state == ITER) && (cnt == 4'(N - 1));
  assign busy  = (state == ITER);
  assign valid = (state == DONE);

`ifdef LINE_RECIP_ROUND_EN
  logic [OUT_W:0] rnd;
  assign rnd     = {1'b0, q_nx[N-1:1]} + (OUT_W+1)'(q_nx[0]);
  assign fin     = rnd[OUT_W-1:0];
  assign fin_sat = s | rnd[OUT_W];
`else
  assign fin     = q_nx[OUT_W-1:0];
  assign fin_sat = s;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = ITER;
      ITER:    if (start) nxt = ITER;
               else if (cnt == 4'(N - 1)) nxt = DONE;
      DONE:    nxt = start ? ITER : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      d     <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      s     <= 1'b0;
      recip <= '0;
      sat   <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        d   <= denom;
        r   <= (DEN_W+1)'(R0);
        q   <= '0;
        cnt <= '0;
        s   <= (denom == '0) || (R0 >= int'(denom));
      end else if (state == ITER) begin
        r   <= r_nx;
        q   <= q_nx;
        cnt <= cnt + 4'd1;
      end
      // Result lands on entry to DONE so it is visible with valid.
      if (last && !start) begin
        recip <= fin_sat ? SAT[OUT_W-1:0] : fin;
        sat   <= fin_sat;
      end
    end
  end

endmodule

// File: tb/tb_line_recip.sv
// Directed bench for line_recip: latency, saturation, abort, sweep, reset.
// Build with LINE_RECIP_ROUND_EN to check the rounding variant.
module tb_line_recip;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  denom;
  logic [10:0] recip;
  logic        busy;
  logic        valid;
  logic        sat;

  int errors = 0;
  int checks = 0;

`ifdef LINE_RECIP_ROUND_EN
  localparam int LAT = 13;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 12;
  localparam bit RND = 1'b0;
`endif

  line_recip dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .denom (denom),
    .recip (recip),
    .busy  (busy),
    .valid (valid),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_r(input int d);
    int q2, v;
    if (d == 0 || 32 >= d) return 2047;
    if (!RND) return 65536 / d;
    q2 = 131072 / d;
    v  = (q2 >> 1) + (q2 & 1);
    return (v >= 2048) ? 2047 : v;
  endfunction

  function automatic int ref_s(input int d);
    return (ref_r(d) == 2047) ? 1 : 0;
  endfunction

  task automatic issue(input int d);
    start = 1'b1;
    denom = 9'(d);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input logic [10:0] prev,
                            output int lat, output int held);
    lat  = 1;
    held = 0;
    while (!valid && lat < 30) begin
      if (recip !== prev) held++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic req(input string tag, input int d,
                     input int er, input int es);
    int lat, held;
    logic [10:0] prev;
    prev = recip;
    issue(d);
    chk({tag, ".busy"}, int'(busy), 1);
    wait_valid(prev, lat, held);
    chk({tag, ".lat"}, lat, LAT);
    chk({tag, ".hold"}, held, 0);
    chk({tag, ".recip"}, int'(recip), er);
    chk({tag, ".sat"}, int'(sat), es);
  endtask

  initial begin
    int lat, held, nv;
    logic [10:0] prev;
    rst   = 1'b1;
    start = 1'b0;
    denom = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.recip", int'(recip), 0);
    chk("rst.sat", int'(sat), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    req("d34", 34, RND ? 1928 : 1927, 0);
    req("d32", 32, 2047, 1);
    req("d33", 33, RND ? 1986 : 1985, 0);
    req("d0", 0, 2047, 1);
    req("d200", 200, RND ? 328 : 327, 0);
    req("d511", 511, 128, 0);

    // Abort: second start five cycles after the first.
    prev = recip;
    issue(300);
    for (int i = 1; i < 5; i++) begin
      chk("abort.novalid", int'(valid), 0);
      chk("abort.hold", int'(recip), int'(prev));
      @(posedge clk); #1;
    end
    issue(255);
    wait_valid(prev, lat, held);
    chk("abort.lat", lat, LAT);
    chk("abort.held", held, 0);
    chk("abort.recip", int'(recip), 257);
    @(posedge clk); #1;
    chk("abort.single", int'(valid), 0);

    // Back-to-back sweep, next start issued in each DONE cycle.
    prev = recip;
    issue(1);
    for (int d = 1; d <= 511; d++) begin
      wait_valid(prev, lat, held);
      chk("sweep.lat", lat, LAT);
      chk("sweep.recip", int'(recip), ref_r(d));
      chk("sweep.sat", int'(sat), ref_s(d));
      if (lat >= 30) break;
      prev = recip;
      if (d < 511) issue(d + 1);
    end
    @(posedge clk); #1;
    chk("sweep.idle", int'(busy), 0);

    // Reset in the middle of an iteration.
    issue(34);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.recip", int'(recip), 0);
    chk("midrst.sat", int'(sat), 0);
    chk("midrst.busy", int'(busy), 0);
    nv = 0;
    repeat (16) begin
      if (valid) nv++;
      @(posedge clk); #1;
    end
    chk("midrst.novalid", nv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_recip.md
# line_recip

Iterative fixed-point reciprocal unit for the per-scanline perspective plane. Once per line it computes `recip ≈ 2^NUM_W / denom` and holds the result stable until the next computation completes. The video core issues `start` 16 cycles before end of active display and samples `recip` at hblank. Result is saturated to `OUT_W` bits, and worst-case latency fits inside that 16-cycle window.

## Interface
- `NUM_W`, default 16: numerator exponent; dividend is `2^NUM_W`.
- `DEN_W`, default 9: denominator width (unsigned).
- `OUT_W`, default 11: result width (unsigned); requires `OUT_W <= NUM_W` and `OUT_W + 2 <= 16`.
- `clk`  in  1: pixel clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request; latches `denom`.
- `denom`  in  `DEN_W`: divisor, sampled only when `start` is high.
- `recip`  out  `OUT_W`: registered result, held between completions.
- `busy`  out  1: computation in progress.
- `valid`  out  1: one-cycle pulse when `recip` updates.
- `sat`  out  1: registered with `recip`; 1 if that result was saturated or `denom == 0`.

## Operation
- **States:** `IDLE`, `ITER`, `DONE`.
  - `IDLE --start--> ITER`
  - `ITER` runs for `N` cycles, then `--> DONE`.
  - `DONE --> IDLE` unconditionally, or `--> ITER` if `start` is asserted that cycle.
- **Start cycle:**
  - Latch `d = denom`.
  - Initial remainder `r0 = 2^(NUM_W-OUT_W)`, held in `DEN_W+1` bits.
  - Saturation flag `s = (d == 0) || (r0 >= d)`; this is exactly quotient `>= 2^OUT_W`.
- **Restoring step, one quotient bit per `ITER` cycle:**
  - `t = {r, 1'b0}`.
  - If `t >= d`: `r = t - d`, `q = {q, 1}`; else `r = t`, `q = {q, 0}`.
  - Remainder never exceeds `2*d - 1`, so `DEN_W+1` bits suffice.
- **Iteration count:** `N = OUT_W` (truncating build) or `OUT_W+1` (rounding build, see Configuration).
- **DONE cycle:**
  - `recip <= s ? {OUT_W{1'b1}} : q[OUT_W-1:0]`.
  - `sat <= s`; `valid = 1`.
- **Saturated requests** still run the full `N` iterations, so latency is data-independent.
- **`start` while `busy`:** abort the current computation, relatch `denom`, restart from iteration 0. `recip` keeps its previous value; no `valid` for the aborted request.
- **`start` in `DONE`:** the current result completes normally (`valid` = 1) and the new request begins the same cycle.
- **Reset:** `recip = 0`, `sat = 0`, `busy = 0`, `valid = 0`, state `IDLE`. `rst` overrides `start` in the same cycle.

## Timing
- `start` at cycle T: `busy` is high from T+1 through T+N.
- `recip`, `sat` and `valid` update at the T+N+1 edge. Latency is 12 cycles (truncating) or 13 (rounding), both within the 16-cycle budget.
- `recip` changes only on a `valid` cycle or on `rst`.
- Throughput: one result every N+1 cycles with back-to-back `start`.

## Configuration
- `LINE_RECIP_ROUND_EN` defined:
  - Perform `OUT_W+1` iterations, producing one guard bit.
  - `recip = (q >> 1) + q[0]` (round half up).
  - If the increment reaches `2^OUT_W`, output all-ones and set `sat`.
- Undefined: `OUT_W` iterations, truncating (floor).

## Structure
- Shared package `line_recip_pkg`:
  - State enum `{IDLE, ITER, DONE}`.
  - Localparam `LINE_RECIP_LAT` = iteration count + 1, selected by the macro.
  - Saturation constant helper.
- One natural sub-module, `line_recip_step`: purely combinational restoring step, `(r, d) -> (r_next, qbit)`. Instantiated once in the loop datapath.

## Test plan
- After reset: `recip = 0`, `sat = 0`, `busy = 0`. Then `start` with `denom = 34` → truncating: `recip = 1927`, `sat = 0`, `valid` exactly 12 cycles after `start`; rounding build: 1928 after 13 cycles.
- Saturation:
  - `denom = 32` → 2047, `sat = 1`.
  - `denom = 33` → 1985, `sat = 0`.
  - `denom = 0` → 2047, `sat = 1`.
  - Each `valid` at fixed latency.
- Rounding: `denom = 200` → 327 (truncating) / 328 (rounding). `denom = 511` → 128 in both builds.
- Abort: `start` with `denom = 300`, then `start` with `denom = 255` five cycles later → a single `valid` 12 cycles after the second `start`, `recip = 257`; `recip` holds its prior value in between.
- Back-to-back and reset:
  - Sweep `denom` 1..511 with `start` issued on each `DONE` cycle → every result matches the floor/round reference model; no `valid` is dropped.
  - `rst` mid-`ITER` → outputs zero next cycle and no `valid` follows.
